// File: rtl/output_port_bank.sv
// output_port_bank: CH independent WIDTH-bit output registers with write/set/clear/toggle ops and read-back.
// Define OUTPORT_PULSE_EN to add a per-channel one-shot timer that auto-clears its channel.
module output_port_bank #(
    parameter int CH      = 4,
    parameter int WIDTH   = 10,
    parameter int PULSE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  nce,
    input  logic                  we,
    input  logic [8:0]            addr,
    input  logic [31:0]           d_in,
    output logic [31:0]           d_out,
    output logic [CH*WIDTH-1:0]   pins
);
    localparam int CHW = $clog2(CH);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic [WIDTH-1:0] r_ch [CH];
    logic [31:0]      r_dout;

    logic [1:0]       w_op;
    logic [CHW-1:0]   w_chan;
    logic             w_region;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_data;
    logic [CH-1:0]    w_port_hit;
    logic [CH-1:0]    w_tmr_hit;
    logic [31:0]      w_port_rd;
    logic [31:0]      w_tmr_rd;
    logic             w_unused;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op
    );
        case (op)
            OP_WRITE:  apply_op = d;
            OP_SET:    apply_op = cur | d;
            OP_CLEAR:  apply_op = cur & ~d;
            OP_TOGGLE: apply_op = cur ^ d;
            default:   apply_op = cur;
        endcase
    endfunction

    assign w_op      = addr[1:0];
    assign w_chan    = addr[2 +: CHW];
    assign w_region  = addr[2+CHW];
    assign w_wr      = !nce && we;
    assign w_rd      = !nce && !we;
    assign w_data    = d_in[WIDTH-1:0];
    assign w_port_rd = 32'(r_ch[w_chan]);
    // Upper address bits and unused data bits are don't-care on this bus.
    assign w_unused  = ^{addr, d_in, PULSE_W};

    // Per-channel write strobes for the port and timer regions.
    always_comb begin
        w_port_hit = '0;
        w_tmr_hit  = '0;
        for (int c = 0; c < CH; c++) begin
            if (w_wr && (w_chan == CHW'(c))) begin
                w_port_hit[c] = !w_region;
                w_tmr_hit[c]  = w_region;
            end else begin
                w_port_hit[c] = 1'b0;
                w_tmr_hit[c]  = 1'b0;
            end
        end
    end

`ifdef OUTPORT_PULSE_EN
    logic [PULSE_W-1:0] r_tmr [CH];

    assign w_tmr_rd = 32'(r_tmr[w_chan]);

    // One-shot timers: reload on a timer write, otherwise count down to zero.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) r_tmr[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (w_tmr_hit[c]) begin
                    r_tmr[c] <= d_in[PULSE_W-1:0];
                end else if (r_tmr[c] != '0) begin
                    r_tmr[c] <= r_tmr[c] - PULSE_W'(1);
                end else begin
                    r_tmr[c] <= r_tmr[c];
                end
            end
        end
    end
`else
    assign w_tmr_rd = 32'd0;
`endif

    // Channel registers; a bus write beats the timer auto-clear on the same edge.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) r_ch[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (w_port_hit[c]) begin
                    r_ch[c] <= apply_op(r_ch[c], w_data, w_op);
`ifdef OUTPORT_PULSE_EN
                end else if ((r_tmr[c] == PULSE_W'(1)) && !w_tmr_hit[c]) begin
                    r_ch[c] <= '0;
`endif
                end else begin
                    r_ch[c] <= r_ch[c];
                end
            end
        end
    end

    // Registered read-back; holds between reads.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_dout <= 32'd0;
        end else if (w_rd) begin
            r_dout <= w_region ? w_tmr_rd : w_port_rd;
        end else begin
            r_dout <= r_dout;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_pins
        assign pins[g*WIDTH +: WIDTH] = r_ch[g];
    end

    assign d_out = r_dout;

endmodule

// File: tb/tb_output_port_bank.sv
// Self-checking bench for output_port_bank: directed test-plan cases plus random traffic
// compared against a transaction-level reference model (honours OUTPORT_PULSE_EN).
module tb_output_port_bank;
    localparam int CH      = 4;
    localparam int WIDTH   = 10;
    localparam int PULSE_W = 16;
    localparam int CHW     = $clog2(CH);

    logic                 clk;
    logic                 rst_n;
    logic                 nce;
    logic                 we;
    logic [8:0]           addr;
    logic [31:0]          d_in;
    logic [31:0]          d_out;
    logic [CH*WIDTH-1:0]  pins;

    int n_tests;
    int n_fail;

    // Reference state: channel values, timer values, read register.
    longint m_ch  [CH];
    longint m_tmr [CH];
    longint m_dout;

    output_port_bank #(.CH(CH), .WIDTH(WIDTH), .PULSE_W(PULSE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .nce   (nce),
        .we    (we),
        .addr  (addr),
        .d_in  (d_in),
        .d_out (d_out),
        .pins  (pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk_addr(input int region, input int c, input int op);
        return 9'((region << (2 + CHW)) + (c << 2) + op);
    endfunction

    function automatic logic [31:0] pin_ch(input int c);
        logic [CH*WIDTH-1:0] p;
        p = pins;
        return 32'(p[c*WIDTH +: WIDTH]);
    endfunction

    // One bus cycle as the spec describes it, computed on whole-transaction level.
    task automatic model_edge(input bit r, input bit n, input bit w, input int a, input longint din);
        longint wmask, pmask, nch [CH], ntm [CH];
        int op, c, region;
        bit pulse;
`ifdef OUTPORT_PULSE_EN
        pulse = 1'b1;
`else
        pulse = 1'b0;
`endif
        wmask  = (64'd1 << WIDTH) - 1;
        pmask  = (64'd1 << PULSE_W) - 1;
        op     = a % 4;
        c      = (a / 4) % CH;
        region = (a / (4 * CH)) % 2;
        if (!r) begin
            foreach (m_ch[i]) begin m_ch[i] = 0; m_tmr[i] = 0; end
            m_dout = 0;
            return;
        end
        foreach (m_ch[i]) begin
            nch[i] = m_ch[i];
            ntm[i] = m_tmr[i];
            if (pulse && m_tmr[i] != 0) begin
                ntm[i] = m_tmr[i] - 1;
                if (m_tmr[i] == 1) nch[i] = 0;
            end
        end
        if (!n && w && region == 0) begin
            case (op)
                0: nch[c] = din & wmask;
                1: nch[c] = m_ch[c] | (din & wmask);
                2: nch[c] = m_ch[c] & ~(din & wmask) & wmask;
                default: nch[c] = m_ch[c] ^ (din & wmask);
            endcase
        end
        if (!n && w && region == 1 && pulse) begin
            ntm[c] = din & pmask;
            nch[c] = m_ch[c];
        end
        if (!n && !w) m_dout = (region == 1) ? (pulse ? m_tmr[c] : 0) : m_ch[c];
        foreach (m_ch[i]) begin m_ch[i] = nch[i]; m_tmr[i] = ntm[i]; end
    endtask

    // Drive one cycle, let the falling edge act, then compare on the rising edge.
    task automatic step(input bit r, input bit n, input bit w, input logic [8:0] a, input logic [31:0] din);
        rst_n = r; nce = n; we = w; addr = a; d_in = din;
        @(negedge clk);
        model_edge(r, n, w, int'(a), longint'(din));
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) check_eq($sformatf("pins_ch%0d", c), pin_ch(c), 32'(m_ch[c]));
        check_eq("d_out", d_out, 32'(m_dout));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        foreach (m_ch[i]) begin m_ch[i] = 0; m_tmr[i] = 0; end
        m_dout = 0;
        rst_n = 1'b0; nce = 1'b1; we = 1'b0; addr = 9'd0; d_in = 32'd0;
        @(posedge clk);

        // Reset for two edges, then WRITE ch0.
        step(1'b0, 1'b1, 1'b0, 9'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 9'd0, 32'd0);
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 0, 0), 32'h3FF);
        check_eq("tp1_ch0", pin_ch(0), 32'h3FF);
        check_eq("tp1_ch1", pin_ch(1), 32'h0);
        check_eq("tp1_dout", d_out, 32'h0);

        // ch1 op sequence with read-back after each op.
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 1, 0), 32'h0F0);
        step(1'b1, 1'b0, 1'b0, mk_addr(0, 1, 2), 32'h0);
        check_eq("tp2_write", d_out, 32'h0F0);
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 1, 1), 32'h00F);
        step(1'b1, 1'b0, 1'b0, mk_addr(0, 1, 0), 32'h0);
        check_eq("tp2_set", d_out, 32'h0FF);
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 1, 2), 32'h030);
        step(1'b1, 1'b0, 1'b0, mk_addr(0, 1, 3), 32'h0);
        check_eq("tp2_clear", d_out, 32'h0CF);
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 1, 3), 32'h101);
        step(1'b1, 1'b0, 1'b0, mk_addr(0, 1, 1), 32'h0);
        check_eq("tp2_toggle", d_out, 32'h000001CE);

        // Back-to-back SET then TOGGLE on ch2, then a write with nce high.
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 2, 1), 32'h055);
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 2, 3), 32'h00F);
        check_eq("b2b_ch2", pin_ch(2), 32'h05A);
        step(1'b1, 1'b1, 1'b1, mk_addr(0, 2, 0), 32'h3FF);
        check_eq("nce_pins", pin_ch(2), 32'h05A);
        step(1'b1, 1'b0, 1'b0, mk_addr(0, 2, 0), 32'h0);
        check_eq("nce_read", d_out, 32'h05A);

        // Reset mid-operation beats a simultaneous write.
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 3, 0), 32'h155);
        step(1'b1, 1'b0, 1'b1, mk_addr(1, 3, 0), 32'd5);
        step(1'b0, 1'b0, 1'b1, mk_addr(0, 3, 0), 32'h2AA);
        check_eq("rst_ch3", pin_ch(3), 32'h0);
        check_eq("rst_dout", d_out, 32'h0);
        step(1'b1, 1'b0, 1'b0, mk_addr(1, 3, 0), 32'h0);
        check_eq("rst_tmr3", d_out, 32'h0);

`ifdef OUTPORT_PULSE_EN
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 0, 0), 32'h3FF);
        step(1'b1, 1'b0, 1'b1, mk_addr(1, 0, 2), 32'd3);
        step(1'b1, 1'b1, 1'b0, 9'd0, 32'h0);
        check_eq("pulse_e1", pin_ch(0), 32'h3FF);
        step(1'b1, 1'b0, 1'b0, mk_addr(1, 0, 0), 32'h0);
        check_eq("pulse_rd2", d_out, 32'd2);
        check_eq("pulse_e2", pin_ch(0), 32'h3FF);
        step(1'b1, 1'b0, 1'b0, mk_addr(1, 0, 0), 32'h0);
        check_eq("pulse_rd1", d_out, 32'd1);
        check_eq("pulse_e3", pin_ch(0), 32'h0);
        // Timer expiry and bus write on the same edge: the bus write wins.
        step(1'b1, 1'b0, 1'b1, mk_addr(1, 0, 0), 32'd1);
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 0, 0), 32'h2AA);
        check_eq("coll_ch0", pin_ch(0), 32'h2AA);
        step(1'b1, 1'b0, 1'b0, mk_addr(1, 0, 0), 32'h0);
        check_eq("coll_tmr0", d_out, 32'd0);
`else
        step(1'b1, 1'b0, 1'b1, mk_addr(0, 0, 0), 32'h3FF);
        step(1'b1, 1'b0, 1'b1, mk_addr(1, 0, 0), 32'd3);
        step(1'b1, 1'b0, 1'b0, mk_addr(1, 0, 0), 32'h0);
        check_eq("notmr_rd", d_out, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 9'd0, 32'h0);
        check_eq("notmr_ch0", pin_ch(0), 32'h3FF);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            bit r, n, w;
            logic [31:0] din;
            r   = ($urandom_range(0, 49) != 0);
            n   = ($urandom_range(0, 4) == 0);
            w   = $urandom_range(0, 1) == 1;
            din = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 6)) : $urandom;
            step(r, n, w, 9'($urandom), din);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_port_bank.md
# output_port_bank

Memory-mapped, multi-channel output port for the MIPS32 data bus: the parametrised successor to the single 10-bit output latch. It holds `CH` independent `WIDTH`-bit output registers that drive the board pins, and supports four atomic write modes: write, set, clear and toggle. Software can read back each channel. An optional per-channel one-shot timer clears a channel automatically after a programmed number of cycles. The block sits on the data-memory bus beside RAM, selected by the address decoder through `nce`.

## Interface

- `CH`, 4, number of output channels; power of two, 2..16.
- `WIDTH`, 10, bits per channel, 1..32.
- `PULSE_W`, 16, one-shot counter width, 1..32 (used only with `OUTPORT_PULSE_EN`).
- `clk` input 1: system clock. All state updates on the falling edge.
- `rst_n` input 1: reset, synchronous, active-low, sampled on the falling edge of `clk`.
- `nce` input 1: chip enable, active-low.
- `we` input 1: write enable. 1 = write, 0 = read.
- `addr` input 9: word address. `[1:0]` = op; `[2 +: CHW]` = channel, where `CHW` = clog2(`CH`); `[2+CHW]` = region (0 = port, 1 = timer). Higher bits are ignored.
- `d_in` input 32: write data.
- `d_out` output 32: registered read data, zero-extended.
- `pins` output `CH*WIDTH`: channel c drives `pins[c*WIDTH +: WIDTH]`.

## Operation

Reset:
- `rst_n`=0 at a falling edge sets all channels to 0, `d_out` to 0 and all timers to 0.
- Reset overrides any bus access or timer event in the same edge.

Port-region write (`nce`=0, `we`=1, region 0), applied to channel c with `D` = `d_in[WIDTH-1:0]`:
- op 00 WRITE: `ch[c] <= D`.
- op 01 SET: `ch[c] <= ch[c] | D`.
- op 10 CLEAR: `ch[c] <= ch[c] & ~D`.
- op 11 TOGGLE: `ch[c] <= ch[c] ^ D`.

Read (`nce`=0, `we`=0):
- Region 0: `d_out <= {0, ch[c]}`, regardless of op.
- Region 1: `d_out <= {0, timer[c]}`.
- Outside a read, `d_out` holds its value.

Other access rules:
- `nce`=1: no state change. `pins` and `d_out` hold.
- Exactly one channel changes per write. All other channels hold.

## Timing

- Write latency: `pins` reflects a write immediately after the falling edge on which `nce`=0 and `we`=1 are sampled. There is no wait state.
- Read latency: `d_out` is valid after the falling edge that samples the read. It is stable for the following rising edge, where the CPU captures it.
- A read and a write to the same channel cannot occur in one edge (`we` is a single bit). A read in the edge after a write returns the new value.
- Back-to-back writes to the same channel on consecutive edges each see the value left by the previous write. For example, SET then TOGGLE compose correctly.

## Configuration

Macro `OUTPORT_PULSE_EN` enables the one-shot timer.

Defined:
- A timer-region write sets `timer[c] <= d_in[PULSE_W-1:0]`. Op bits are ignored.
- Each falling edge with `timer[c]` ≠ 0, the timer decrements by 1.
- On the edge where `timer[c]` goes from 1 to 0, `ch[c] <= 0` (auto-clear).
- If a port-region write to channel c lands on that same edge, the bus write wins and the timer still reaches 0.
- Writing 0 to a timer cancels a pending clear.
- Writing a timer while it is running reloads it with the new value. The old value is discarded.

Undefined:
- Timer-region writes are ignored and timer-region reads return 0.
- No counter logic is synthesised.

## Test plan

- Reset with `rst_n`=0 for 2 edges, then write ch0 WRITE 0x3FF: `pins[9:0]`=0x3FF after that edge; all other channels 0; `d_out`=0.
- ch1: WRITE 0x0F0, SET 0x00F, CLEAR 0x030, TOGGLE 0x101; read ch1: `d_out` sequence of channel values 0x0F0, 0x0FF, 0x0CF, 0x1CE; `d_out`=0x000001CE.
- Write with `nce`=1 and `we`=1, `d_in`=0x3FF to ch2: `pins` unchanged; a following read of ch2 returns the previous value.
- Reset mid-operation: ch3=0x155 and timer3=5, assert `rst_n`=0 together with a WRITE to ch3: ch3=0, timer3=0, `d_out`=0.
- With `OUTPORT_PULSE_EN`: ch0=0x3FF, timer0 written 3: `pins[9:0]` stays 0x3FF for 2 edges and goes to 0 on the 3rd edge; reading timer0 on the intervening edges returns 2 and 1.
- With `OUTPORT_PULSE_EN`, simultaneous event: timer0=1 and WRITE ch0 0x2AA on the same edge: ch0=0x2AA and timer0=0. Without the macro, timer0 write 3 then read returns 0 and ch0 is never cleared.
